// File: rtl/laser_pkg.sv
// ----------------------------------------------------------------------------
// laser_pkg
// Shared constants and types for the LASER host driver/scorer.
//   NUM_POINTS : size of the target point set
//   COORD_W    : width of one coordinate
//   RADIUS_SQ  : squared radius of the coverage disc
//   state_t    : host sequencer states
//   pt_t       : one stored point, packed as {y, x}
// ----------------------------------------------------------------------------
package laser_pkg;

    localparam int NUM_POINTS = 40;
    localparam int COORD_W    = 4;
    localparam int RADIUS_SQ  = 16;
    localparam int ADDR_W     = 6;
    localparam int SCORE_W    = 6;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_POINTS - 1);
    localparam logic [ADDR_W-1:0] NUM_PTS_A = ADDR_W'(NUM_POINTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        SCORE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } pt_t;

endpackage

// File: rtl/laser_disc_hit.sv
// ----------------------------------------------------------------------------
// laser_disc_hit
// Purely combinational disc test: a point hits when dx^2 + dy^2 <= RADIUS_SQ
// relative to the given centre. Distances are unsigned 4-bit magnitudes,
// squares are 8-bit, the sum is kept in 9 bits so it cannot wrap.
//   i_cx, i_cy : circle centre
//   i_px, i_py : point under test
//   o_hit      : point lies inside or on the disc
// ----------------------------------------------------------------------------
module laser_disc_hit
    import laser_pkg::*;
(
    input  logic [COORD_W-1:0] i_cx,
    input  logic [COORD_W-1:0] i_cy,
    input  logic [COORD_W-1:0] i_px,
    input  logic [COORD_W-1:0] i_py,
    output logic               o_hit
);

    logic [COORD_W-1:0]   w_dx;
    logic [COORD_W-1:0]   w_dy;
    logic [2*COORD_W-1:0] w_dx_sq;
    logic [2*COORD_W-1:0] w_dy_sq;
    logic [2*COORD_W:0]   w_sum;

    assign w_dx    = (i_px >= i_cx) ? (i_px - i_cx) : (i_cx - i_px);
    assign w_dy    = (i_py >= i_cy) ? (i_py - i_cy) : (i_cy - i_py);
    assign w_dx_sq = {{COORD_W{1'b0}}, w_dx} * {{COORD_W{1'b0}}, w_dx};
    assign w_dy_sq = {{COORD_W{1'b0}}, w_dy} * {{COORD_W{1'b0}}, w_dy};
    assign w_sum   = {1'b0, w_dx_sq} + {1'b0, w_dy_sq};
    assign o_hit   = (w_sum <= (2*COORD_W+1)'(RADIUS_SQ));

endmodule

// File: rtl/laser_host.sv
// ----------------------------------------------------------------------------
// laser_host
// Host-side driver and scorer for the LASER dual-circle coverage engine.
// Holds the 40-point target set, streams it to the engine one point per
// clock after releasing the engine reset, waits for DONE (bounded by
// TIMEOUT_CYCLES), captures both centres and re-scores them against the
// stored points, reporting with a one-cycle res_valid pulse.
//   CLK, RST                 : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_x/wr_y  : point write port (idle only, addr < 40)
//   start                    : run request (idle only)
//   LRST, X, Y               : engine reset and point stream (registered)
//   C1X..C2Y, DONE           : engine result
//   busy                     : sequencer not idle
//   res_valid/res_score/res_timeout/res_c1x..res_c2y : result
// ----------------------------------------------------------------------------
module laser_host
    import laser_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               start,
    output logic               LRST,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    input  logic [COORD_W-1:0] C1X,
    input  logic [COORD_W-1:0] C1Y,
    input  logic [COORD_W-1:0] C2X,
    input  logic [COORD_W-1:0] C2Y,
    input  logic               DONE,
    output logic               busy,
    output logic               res_valid,
    output logic [SCORE_W-1:0] res_score,
    output logic               res_timeout,
    output logic [COORD_W-1:0] res_c1x,
    output logic [COORD_W-1:0] res_c1y,
    output logic [COORD_W-1:0] res_c2x,
    output logic [COORD_W-1:0] res_c2y
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;

    pt_t                 r_pts [NUM_POINTS];
    logic [ADDR_W-1:0]   r_idx;
    logic [15:0]         r_tmo;
    logic [SCORE_W-1:0]  r_acc;

    logic                r_lrst;
    pt_t                 r_out_pt;
    logic                r_valid;
    logic                r_timeout;
    logic [SCORE_W-1:0]  r_score;
    logic [COORD_W-1:0]  r_c1x, r_c1y, r_c2x, r_c2y;

    logic                w_wr_ok;
    logic                w_last;
    logic                w_tmo_hit;
    pt_t                 w_pt0;
    pt_t                 w_pt_next;
    pt_t                 w_pt_cur;
    logic                w_hit1, w_hit2, w_hit;

    // Sequencer control decodes.
    logic                w_busy;
    logic                w_launch;
    logic                w_step;
    logic                w_stream_end;
    logic                w_capture;
    logic                w_abort;
    logic                w_finish;

    assign w_wr_ok   = wr_en && (r_state == IDLE) && (wr_addr < NUM_PTS_A);
    assign w_last    = (r_idx == LAST_IDX);
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    // A write to entry 0 in the launch cycle lands in the same edge that
    // loads X/Y, so forward the incoming value instead of the stale entry.
    assign w_pt0     = (w_wr_ok && (wr_addr == '0)) ? pt_t'{y: wr_y, x: wr_x}
                                                    : r_pts[0];
    assign w_pt_next = r_pts[r_idx + ADDR_W'(1)];
    assign w_pt_cur  = r_pts[r_idx];

    laser_disc_hit u_hit_c1 (
        .i_cx  (r_c1x),
        .i_cy  (r_c1y),
        .i_px  (w_pt_cur.x),
        .i_py  (w_pt_cur.y),
        .o_hit (w_hit1)
    );

    laser_disc_hit u_hit_c2 (
        .i_cx  (r_c2x),
        .i_cy  (r_c2y),
        .i_px  (w_pt_cur.x),
        .i_py  (w_pt_cur.y),
        .o_hit (w_hit2)
    );

    assign w_hit = w_hit1 | w_hit2;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: w_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = STREAM;
            STREAM:  if (w_last) w_next = WAIT;
            WAIT: begin
                if (DONE)           w_next = SCORE;
                else if (w_tmo_hit) w_next = IDLE;
            end
            SCORE:   if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_busy       = 1'b0;
        w_launch     = 1'b0;
        w_step       = 1'b0;
        w_stream_end = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE:   w_launch = start;
            STREAM: begin
                w_busy       = 1'b1;
                w_step       = !w_last;
                w_stream_end = w_last;
            end
            WAIT: begin
                w_busy    = 1'b1;
                w_capture = DONE;
                w_abort   = !DONE && w_tmo_hit;
            end
            SCORE: begin
                w_busy   = 1'b1;
                w_finish = w_last;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Point memory
    // ------------------------------------------------------------------
    // NOTE: the point file is deliberately reset so a run after RST always
    // streams zeros; this keeps it out of RAM macros, acceptable at 40x8.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_POINTS; i++) r_pts[i] <= '0;
        end else if (w_wr_ok) begin
            r_pts[wr_addr] <= pt_t'{y: wr_y, x: wr_x};
        end
    end

    // ------------------------------------------------------------------
    // Datapath: stream index, timeout counter, scoring, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx     <= '0;
            r_tmo     <= '0;
            r_acc     <= '0;
            r_lrst    <= 1'b1;
            r_out_pt  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_score   <= '0;
            r_c1x     <= '0;
            r_c1y     <= '0;
            r_c2x     <= '0;
            r_c2y     <= '0;
        end else begin
            // Engine held in reset whenever the sequencer is (about to be)
            // idle, so a stale DONE never survives into the next run.
            r_lrst    <= (w_next == IDLE);
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;

            if (w_launch) begin
                r_idx    <= '0;
                r_out_pt <= w_pt0;
            end

            if (w_step) begin
                r_idx    <= r_idx + ADDR_W'(1);
                r_out_pt <= w_pt_next;
            end

            if (w_stream_end) r_tmo <= '0;
            if (r_state == WAIT) r_tmo <= r_tmo + 16'd1;

            if (w_capture) begin
                r_c1x <= C1X;
                r_c1y <= C1Y;
                r_c2x <= C2X;
                r_c2y <= C2Y;
                r_acc <= '0;
                r_idx <= '0;
            end

            if (w_abort) begin
                r_valid   <= 1'b1;
                r_timeout <= 1'b1;
                r_score   <= '0;
            end

            if (r_state == SCORE) begin
                r_idx <= r_idx + ADDR_W'(1);
                r_acc <= r_acc + SCORE_W'(w_hit);
            end

            if (w_finish) begin
                r_score <= r_acc + SCORE_W'(w_hit);
                r_valid <= 1'b1;
            end
        end
    end

    assign LRST        = r_lrst;
    assign X           = r_out_pt.x;
    assign Y           = r_out_pt.y;
    assign busy        = w_busy;
    assign res_valid   = r_valid;
    assign res_timeout = r_timeout;
    assign res_score   = r_score;
    assign res_c1x     = r_c1x;
    assign res_c1y     = r_c1y;
    assign res_c2x     = r_c2x;
    assign res_c2y     = r_c2y;

endmodule

// File: tb/tb_laser_host.sv
// ----------------------------------------------------------------------------
// tb_laser_host
// Directed bench for laser_host with a behavioural engine model that records
// the streamed points and raises DONE a programmable number of cycles after
// its reset is released.
// ----------------------------------------------------------------------------
module tb_laser_host;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [3:0] wr_x = '0, wr_y = '0;
    logic       start = 1'b0;
    logic       LRST;
    logic [3:0] X, Y;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic       DONE = 1'b0;
    logic       busy;
    logic       res_valid;
    logic [5:0] res_score;
    logic       res_timeout;
    logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural engine
    logic       eng_en = 1'b0;
    int         eng_delay = 45;
    logic [3:0] eng_c1x = '0, eng_c1y = '0, eng_c2x = '0, eng_c2y = '0;
    int         eng_cnt = 0;
    logic [7:0] cap [40];

    assign C1X = eng_c1x;
    assign C1Y = eng_c1y;
    assign C2X = eng_c2x;
    assign C2Y = eng_c2y;

    laser_host #(.TIMEOUT_CYCLES(100)) dut (
        .CLK(CLK), .RST(RST),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .start(start),
        .LRST(LRST), .X(X), .Y(Y),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
        .busy(busy),
        .res_valid(res_valid), .res_score(res_score), .res_timeout(res_timeout),
        .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (LRST) begin
            eng_cnt <= 0;
            DONE    <= 1'b0;
        end else begin
            if (eng_cnt < 40) cap[eng_cnt] <= {Y, X};
            eng_cnt <= eng_cnt + 1;
            if (eng_en && eng_cnt == eng_delay) DONE <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_pt(input int addr, input int x, input int y);
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 6'(addr); wr_x = 4'(x); wr_y = 4'(y);
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    // Returns at the negedge just after the edge that sampled start (n = 0).
    task automatic start_run();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Advances negedge by negedge until res_valid, bounded.
    task automatic wait_valid(input int n0, output int n);
        n = n0;
        while (n < n0 + 400) begin
            @(negedge CLK);
            n++;
            if (res_valid) break;
        end
        check("valid_seen", 32'(res_valid), 32'd1);
    endtask

    task automatic check_caps_zero(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < 40; k++) if (cap[k] !== 8'h00) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        int extra;
        logic [3:0] kx, ky;

        // ---------------- reset state ----------------
        repeat (2) @(negedge CLK);
        check("rst_lrst",  32'(LRST), 32'd1);
        check("rst_xy",    32'({Y, X}), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_score", 32'(res_score), 32'd0);
        RST = 1'b0;

        // ---------------- stream timing ----------------
        for (int k = 0; k < 40; k++) write_pt(k, k + 3, k);
        eng_en = 1'b1; eng_delay = 45;
        eng_c1x = 4'd0; eng_c1y = 4'd0; eng_c2x = 4'd15; eng_c2y = 4'd15;
        start_run();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_lrst_0", 32'(LRST), 32'd0);
        for (int i = 1; i < 40; i++) begin
            @(negedge CLK);
            check("t1_lrst_low", 32'(LRST), 32'd0);
        end
        wait_valid(39, n);
        check("t1_latency", 32'(n), 32'd87);
        // Hits: k = 0, 16, 32 near (0,0); k = 12, 28 near (15,15).
        check("t1_score", 32'(res_score), 32'd5);
        for (int k = 0; k < 40; k++) begin
            ky = k[3:0];
            kx = 4'(k + 3);
            check("t1_stream_pt", 32'(cap[k]), 32'({ky, kx}));
        end

        // ---------------- scoring with model centres ----------------
        for (int k = 0; k < 40; k++) begin
            if (k < 10)      write_pt(k, 4, 0);
            else if (k < 20) write_pt(k, 3, 3);
            else if (k < 30) write_pt(k, 12, 15);
            else             write_pt(k, 11, 12);
        end
        start_run();
        wait_valid(0, n);
        check("t2_score",   32'(res_score), 32'd20);
        check("t2_timeout", 32'(res_timeout), 32'd0);
        check("t2_c", 32'({res_c1x, res_c1y, res_c2x, res_c2y}), 32'h00FF);

        // ---------------- full coverage, single pulse ----------------
        for (int k = 0; k < 40; k++) write_pt(k, 5, 5);
        eng_c1x = 4'd5; eng_c1y = 4'd1; eng_c2x = 4'd0; eng_c2y = 4'd0;
        start_run();
        wait_valid(0, n);
        check("t3_score", 32'(res_score), 32'd40);
        @(negedge CLK);
        check("t3_valid_drop", 32'(res_valid), 32'd0);
        check("t3_lrst", 32'(LRST), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (res_valid) extra++;
        end
        check("t3_single_pulse", 32'(extra), 32'd0);
        check("t3_score_hold", 32'(res_score), 32'd40);

        // ---------------- timeout ----------------
        eng_en = 1'b0;
        start_run();
        wait_valid(0, n);
        check("t4_latency", 32'(n), 32'd140);
        check("t4_timeout", 32'(res_timeout), 32'd1);
        check("t4_score", 32'(res_score), 32'd0);
        check("t4_c_hold", 32'({res_c1x, res_c1y, res_c2x, res_c2y}), 32'h5100);
        @(negedge CLK);
        check("t4_timeout_drop", 32'(res_timeout), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);

        // ---------------- reset mid-stream ----------------
        eng_en = 1'b1; eng_delay = 45;
        start_run();
        repeat (20) @(negedge CLK);
        check("t5_xy_before", 32'({Y, X}), 32'h55);
        RST = 1'b1;
        #1;
        check("t5_lrst", 32'(LRST), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_xy",   32'({Y, X}), 32'd0);
        check("t5_c1x",  32'(res_c1x), 32'd0);
        check("t5_score", 32'(res_score), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Out-of-range write while idle must not land anywhere.
        write_pt(45, 7, 7);

        // Run with lockout attempts during WAIT.
        eng_delay = 60;
        start_run();
        repeat (50) @(negedge CLK);
        check("t6_busy_wait", 32'(busy), 32'd1);
        start = 1'b1; wr_en = 1'b1; wr_addr = 6'd5; wr_x = 4'd9; wr_y = 4'd9;
        @(negedge CLK);
        start = 1'b0; wr_en = 1'b0;
        wait_valid(51, n);
        check("t6_latency", 32'(n), 32'd102);
        check("t6_score", 32'(res_score), 32'd40);
        check_caps_zero("t6_stream_zero");

        // Same-cycle write to entry 0 and start: stream uses the new value.
        eng_delay = 45;
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 6'd0; wr_x = 4'd2; wr_y = 4'd1; start = 1'b1;
        @(negedge CLK);
        wr_en = 1'b0; start = 1'b0;
        wait_valid(0, n);
        check("t7_pt0_fwd", 32'(cap[0]), 32'h12);
        check("t7_pt5_locked", 32'(cap[5]), 32'h00);
        cap[0] = 8'h00;
        check_caps_zero("t7_rest_zero");
        check("t7_score", 32'(res_score), 32'd40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
